// File: rtl/axil_pkg.sv
// -----------------------------------------------------------------------------
// axil_pkg
// Shared AXI4-Lite definitions for the register-file slave and its channel
// buffers: the response type, the response codes and a byte-strobe merge helper.
// No ports (package).
// -----------------------------------------------------------------------------
package axil_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Merge one byte lane: the new byte wins only when its strobe is set.
  function automatic logic [7:0] strb_byte(input logic [7:0] old_byte,
                                           input logic [7:0] new_byte,
                                           input logic       strb);
    return strb ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/axil_chan_buf.sv
// -----------------------------------------------------------------------------
// axil_chan_buf
// One-entry valid/ready holding register for a single AXI4-Lite request channel
// (AW address or W {strb,data}). Accepts one beat, then holds it until the
// parent pulses clear.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the buffer)
//   in_valid   upstream valid
//   in_ready   upstream ready (low while full, held off, or in reset)
//   in_data    upstream payload [WIDTH-1:0]
//   hold       parent back-pressure (e.g. a write response is outstanding)
//   clear      parent consumed the stored beat
//   full       a beat is stored
//   data       stored payload [WIDTH-1:0]
// -----------------------------------------------------------------------------
module axil_chan_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             hold,
  input  logic             clear,
  output logic             full,
  output logic [WIDTH-1:0] data
);

  logic             full_q;
  logic [WIDTH-1:0] data_q;

  // Ready depends only on stored state and the parent's hold, never on in_valid.
  assign in_ready = !full_q && !hold && !rst;
  assign full     = full_q;
  assign data     = data_q;

  // Capture a beat on handshake. Accept and clear can never coincide: accept
  // needs the buffer empty, clear is only issued while it is full.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid && in_ready) begin
      full_q <= 1'b1;
      data_q <= in_data;
    end else if (clear) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// -----------------------------------------------------------------------------
// axil_regfile_slave
// AXI4-Lite slave terminating one channel set in a bank of NUM_REGS read/write
// registers. AW and W are captured independently in one-entry buffers and
// committed together; reads are a single-beat registered pipeline.
// Optional feature: define AXIL_REGFILE_WPULSE_EN to add reg_wr_pulse, a
// one-cycle per-register strobe after each in-range write commit.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   s_aw{valid,ready,addr}        write address channel
//   s_w{valid,ready,data,strb}    write data channel
//   s_b{valid,ready,resp}         write response channel
//   s_ar{valid,ready,addr}        read address channel
//   s_r{valid,ready,data,resp}    read data channel
//   reg_wr_pulse                  (optional) per-register write strobe
//   regs_out                      flat register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_awvalid,
  output logic                           s_awready,
  input  logic [ADDR_WIDTH-1:0]          s_awaddr,
  input  logic                           s_wvalid,
  output logic                           s_wready,
  input  logic [DATA_WIDTH-1:0]          s_wdata,
  input  logic [STRB_WIDTH-1:0]          s_wstrb,
  output logic                           s_bvalid,
  input  logic                           s_bready,
  output logic [1:0]                     s_bresp,
  input  logic                           s_arvalid,
  output logic                           s_arready,
  input  logic [ADDR_WIDTH-1:0]          s_araddr,
  output logic                           s_rvalid,
  input  logic                           s_rready,
  output logic [DATA_WIDTH-1:0]          s_rdata,
  output logic [1:0]                     s_rresp,
`ifdef AXIL_REGFILE_WPULSE_EN
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
`endif
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out
);

  localparam int ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int IDX_W    = $clog2(NUM_REGS);
  localparam int TOP_LSB  = ADDR_LSB + IDX_W;

  logic                  aw_full;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [STRB_WIDTH+DATA_WIDTH-1:0] w_buf;
  logic [STRB_WIDTH-1:0] w_strb;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  commit;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in_range;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in_range;
  logic                  ar_hs;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Both request buffers stall while a write response is outstanding, so a
  // new write cannot be accepted until the previous one has been acknowledged.
  axil_chan_buf #(.WIDTH(ADDR_WIDTH)) u_aw_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_awvalid),
    .in_ready (s_awready),
    .in_data  (s_awaddr),
    .hold     (s_bvalid),
    .clear    (commit),
    .full     (aw_full),
    .data     (aw_addr)
  );

  axil_chan_buf #(.WIDTH(STRB_WIDTH + DATA_WIDTH)) u_w_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (s_wvalid),
    .in_ready (s_wready),
    .in_data  ({s_wstrb, s_wdata}),
    .hold     (s_bvalid),
    .clear    (commit),
    .full     (w_full),
    .data     (w_buf)
  );

  assign {w_strb, w_data} = w_buf;

  // A write commits once both halves are buffered and no response is pending.
  // Any address bit above the register index makes the access out of range.
  assign commit      = aw_full && w_full && !s_bvalid;
  assign wr_idx      = aw_addr[ADDR_LSB +: IDX_W];
  assign wr_in_range = (aw_addr >> TOP_LSB) == '0;

  assign ar_hs       = s_arvalid && s_arready;
  assign rd_idx      = s_araddr[ADDR_LSB +: IDX_W];
  assign rd_in_range = (s_araddr >> TOP_LSB) == '0;
  assign s_arready   = !s_rvalid && !rst;

  // Register bank: byte-strobed update on an in-range commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VAL;
      end
    end else if (commit && wr_in_range) begin
      for (int k = 0; k < STRB_WIDTH; k++) begin
        regs[wr_idx][8*k +: 8] <= strb_byte(regs[wr_idx][8*k +: 8], w_data[8*k +: 8], w_strb[k]);
      end
    end
  end

  // Write response: raised on commit, held with a stable code until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_bvalid <= 1'b0;
      s_bresp  <= RESP_OKAY;
    end else if (commit) begin
      s_bvalid <= 1'b1;
      s_bresp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_bvalid && s_bready) begin
      s_bvalid <= 1'b0;
    end
  end

  // Read pipeline: data is sampled from the bank on the AR handshake edge, so a
  // commit landing on that same edge is not yet visible to this read.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_in_range ? regs[rd_idx] : '0;
      s_rresp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

`ifdef AXIL_REGFILE_WPULSE_EN
  // One-cycle strobe for the register just written, independent of strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_wr_pulse <= '0;
    end else begin
      reg_wr_pulse <= '0;
      if (commit && wr_in_range) begin
        reg_wr_pulse[wr_idx] <= 1'b1;
      end
    end
  end
`endif

  // Flatten the bank for the status/control consumers.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
    assign regs_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_axil_regfile_slave.sv
// -----------------------------------------------------------------------------
// tb_axil_regfile_slave
// Self-checking bench for axil_regfile_slave with default parameters
// (32-bit data, 16 registers, reset value 0). A table of single write/read
// transactions with hand-computed results is followed by directed sequences
// for the multi-cycle corner cases. Inputs change on the falling edge and
// outputs are sampled there too, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_axil_regfile_slave;
  import axil_pkg::*;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int SW      = 4;
  localparam int NR      = 16;
  localparam int TIMEOUT = 50;

  logic           clk;
  logic           rst;
  logic           s_awvalid;
  logic           s_awready;
  logic [AW-1:0]  s_awaddr;
  logic           s_wvalid;
  logic           s_wready;
  logic [DW-1:0]  s_wdata;
  logic [SW-1:0]  s_wstrb;
  logic           s_bvalid;
  logic           s_bready;
  logic [1:0]     s_bresp;
  logic           s_arvalid;
  logic           s_arready;
  logic [AW-1:0]  s_araddr;
  logic           s_rvalid;
  logic           s_rready;
  logic [DW-1:0]  s_rdata;
  logic [1:0]     s_rresp;
  logic [NR*DW-1:0] regs_out;
`ifdef AXIL_REGFILE_WPULSE_EN
  logic [NR-1:0]  reg_wr_pulse;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] model [NR];

  typedef struct {
    bit          is_write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  axil_regfile_slave dut (
    .clk       (clk),
    .rst       (rst),
    .s_awvalid (s_awvalid),
    .s_awready (s_awready),
    .s_awaddr  (s_awaddr),
    .s_wvalid  (s_wvalid),
    .s_wready  (s_wready),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_bvalid  (s_bvalid),
    .s_bready  (s_bready),
    .s_bresp   (s_bresp),
    .s_arvalid (s_arvalid),
    .s_arready (s_arready),
    .s_araddr  (s_araddr),
    .s_rvalid  (s_rvalid),
    .s_rready  (s_rready),
    .s_rdata   (s_rdata),
    .s_rresp   (s_rresp),
`ifdef AXIL_REGFILE_WPULSE_EN
    .reg_wr_pulse (reg_wr_pulse),
`endif
    .regs_out  (regs_out)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
    return f;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRegs(input string name);
    n_checks++;
    if (regs_out !== model_flat()) begin
      n_fail++;
      $display("[TB] FAIL %s: regs_out 0x%0h, expected 0x%0h", name, regs_out, model_flat());
    end
  endtask

  // Full write with bready held high; lat counts falling edges from presenting
  // AW+W until bvalid is seen. Called and returns on a falling edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp, output int lat);
    bit aw_hs;
    bit w_hs;
    lat       = 0;
    s_awaddr  = addr;
    s_wdata   = data;
    s_wstrb   = strb;
    s_awvalid = 1'b1;
    s_wvalid  = 1'b1;
    s_bready  = 1'b1;
    while ((s_awvalid || s_wvalid) && lat < TIMEOUT) begin
      aw_hs = s_awvalid && s_awready;
      w_hs  = s_wvalid && s_wready;
      @(negedge clk);
      lat++;
      if (aw_hs) s_awvalid = 1'b0;
      if (w_hs)  s_wvalid  = 1'b0;
    end
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    while (!s_bvalid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("write_bvalid_seen", s_bvalid, 1);
    resp = s_bresp;
    @(negedge clk);
    s_bready = 1'b0;
    checkOutput("write_bvalid_clear", s_bvalid, 0);
  endtask

  // Full read with rready held high. Called and returns on a falling edge.
  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    bit ar_hs;
    cyc       = 0;
    s_araddr  = addr;
    s_arvalid = 1'b1;
    s_rready  = 1'b1;
    while (s_arvalid && cyc < TIMEOUT) begin
      ar_hs = s_arready;
      @(negedge clk);
      cyc++;
      if (ar_hs) s_arvalid = 1'b0;
    end
    s_arvalid = 1'b0;
    while (!s_rvalid && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("read_rvalid_seen", s_rvalid, 1);
    data = s_rdata;
    resp = s_rresp;
    @(negedge clk);
    s_rready = 1'b0;
    checkOutput("read_rvalid_clear", s_rvalid, 0);
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;
    if (v.is_write) begin
      axi_write(v.addr, v.wdata, v.wstrb, resp, lat);
      checkOutput($sformatf("vec%0d_bresp", idx), resp, v.exp_resp);
      checkOutput($sformatf("vec%0d_latency", idx), lat, 2);
      if (v.exp_resp == RESP_OKAY) begin
        for (int k = 0; k < SW; k++)
          if (v.wstrb[k]) model[v.addr[5:2]][8*k +: 8] = v.wdata[8*k +: 8];
      end
      checkRegs($sformatf("vec%0d_regs", idx));
    end else begin
      axi_read(v.addr, rdata, resp);
      checkOutput($sformatf("vec%0d_rdata", idx), rdata, v.exp_rdata);
      checkOutput($sformatf("vec%0d_rresp", idx), resp, v.exp_resp);
    end
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;

    rst = 1'b1;
    s_awvalid = 1'b0; s_awaddr = '0;
    s_wvalid  = 1'b0; s_wdata  = '0; s_wstrb = '0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0; s_araddr = '0;
    s_rready  = 1'b0;
    for (int i = 0; i < NR; i++) model[i] = '0;

    vecs.push_back('{1'b1, 32'h08,       32'hDEADBEEF, 4'hF, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h08,       32'h0,        4'h0, RESP_OKAY,   32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h04,       32'hFFFFFFFF, 4'hF, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h04,       32'h0,        4'h0, RESP_OKAY,   32'hFFFFFFFF});
    vecs.push_back('{1'b1, 32'h0C,       32'h11223344, 4'h5, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h0C,       32'h0,        4'h0, RESP_OKAY,   32'h00220044});
    vecs.push_back('{1'b1, 32'h3E,       32'hA5A5A5A5, 4'hF, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h3C,       32'h0,        4'h0, RESP_OKAY,   32'hA5A5A5A5});
    vecs.push_back('{1'b0, 32'h40,       32'h0,        4'h0, RESP_SLVERR, 32'h0});
    vecs.push_back('{1'b1, 32'h40,       32'h12345678, 4'hF, RESP_SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h00,       32'h0,        4'h0, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b1, 32'h08,       32'h0000CC00, 4'h2, RESP_OKAY,   32'h0});
    vecs.push_back('{1'b0, 32'h0A,       32'h0,        4'h0, RESP_OKAY,   32'hDEADCCEF});
    vecs.push_back('{1'b1, 32'h10000000, 32'h55AA55AA, 4'hF, RESP_SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h7C,       32'h0,        4'h0, RESP_SLVERR, 32'h0});
    vecs.push_back('{1'b0, 32'h3D,       32'h0,        4'h0, RESP_OKAY,   32'hA5A5A5A5});

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_awready", s_awready, 0);
    checkOutput("rst_wready",  s_wready,  0);
    checkOutput("rst_arready", s_arready, 0);
    checkOutput("rst_bvalid",  s_bvalid,  0);
    checkOutput("rst_rvalid",  s_rvalid,  0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_awready", s_awready, 1);
    checkOutput("idle_wready",  s_wready,  1);
    checkOutput("idle_arready", s_arready, 1);
    checkOutput("idle_rdata",   s_rdata,   0);
    checkOutput("idle_bresp",   s_bresp,   0);
    checkOutput("idle_rresp",   s_rresp,   0);
    checkRegs("idle_regs");

    // Table-driven single transactions
    for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

    // W arrives three cycles before AW: low half of reg1 replaced
    s_wdata = 32'h1234ABCD; s_wstrb = 4'h3; s_wvalid = 1'b1; s_bready = 1'b1;
    @(negedge clk);
    s_wvalid = 1'b0;
    checkOutput("wfirst_wready_low",  s_wready,  0);
    checkOutput("wfirst_awready_high", s_awready, 1);
    repeat (2) @(negedge clk);
    checkOutput("wfirst_no_commit", s_bvalid, 0);
    s_awaddr = 32'h04; s_awvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0;
    checkOutput("wfirst_bvalid_not_yet", s_bvalid, 0);
    @(negedge clk);
    checkOutput("wfirst_bvalid", s_bvalid, 1);
    checkOutput("wfirst_bresp",  s_bresp,  RESP_OKAY);
    model[1] = 32'hFFFFABCD;
    checkRegs("wfirst_regs");
`ifdef AXIL_REGFILE_WPULSE_EN
    checkOutput("wfirst_pulse", reg_wr_pulse, 16'h0002);
`endif
    @(negedge clk);
    s_bready = 1'b0;
    axi_read(32'h04, rdata, resp);
    checkOutput("wfirst_readback", rdata, 32'hFFFFABCD);

    // Response stall: out-of-range write held 5 cycles, second write waits
    s_bready = 1'b0;
    s_awaddr = 32'h80; s_wdata = 32'h77777777; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    s_awaddr = 32'h18; s_wdata = 32'h66666666; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d_awready", i), s_awready, 0);
      checkOutput($sformatf("stall%0d_wready", i),  s_wready,  0);
      checkOutput($sformatf("stall%0d_bvalid", i),  s_bvalid,  1);
      checkOutput($sformatf("stall%0d_bresp", i),   s_bresp,   RESP_SLVERR);
      @(negedge clk);
    end
    checkRegs("stall_regs_untouched");
    s_bready = 1'b1;
    @(negedge clk);
    checkOutput("stall_bvalid_cleared", s_bvalid, 0);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    checkOutput("stall_second_bvalid", s_bvalid, 1);
    checkOutput("stall_second_bresp",  s_bresp,  RESP_OKAY);
    @(negedge clk);
    s_bready = 1'b0;
    model[6] = 32'h66666666;
    checkRegs("stall_second_regs");

    // AR handshake on the same edge as a reg3 commit returns the old value
    s_awaddr = 32'h0C; s_wdata = 32'hCAFEF00D; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 32'h0C; s_arvalid = 1'b1; s_rready = 1'b1;
    checkOutput("race_arready", s_arready, 1);
    @(negedge clk);
    s_arvalid = 1'b0;
    checkOutput("race_rvalid", s_rvalid, 1);
    checkOutput("race_old_value", s_rdata, 32'h00220044);
    checkOutput("race_bvalid", s_bvalid, 1);
    @(negedge clk);
    s_rready = 1'b0; s_bready = 1'b0;
    model[3] = 32'hCAFEF00D;
    axi_read(32'h0C, rdata, resp);
    checkOutput("race_new_value", rdata, 32'hCAFEF00D);

    // Reset while both responses are pending
    s_awaddr = 32'h1C; s_wdata = 32'h13579BDF; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 32'h08; s_arvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    @(negedge clk);
    checkOutput("prerst_bvalid", s_bvalid, 1);
    checkOutput("prerst_rvalid", s_rvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_bvalid",  s_bvalid,  0);
    checkOutput("midrst_rvalid",  s_rvalid,  0);
    checkOutput("midrst_awready", s_awready, 0);
    checkOutput("midrst_arready", s_arready, 0);
    for (int i = 0; i < NR; i++) model[i] = '0;
    checkRegs("midrst_regs");
    rst = 1'b0;
    @(negedge clk);
    axi_write(32'h08, 32'h0BADF00D, 4'hF, resp, lat);
    checkOutput("postrst_bresp", resp, RESP_OKAY);
    checkOutput("postrst_latency", lat, 2);
    model[2] = 32'h0BADF00D;
    axi_read(32'h08, rdata, resp);
    checkOutput("postrst_readback", rdata, 32'h0BADF00D);

    // A buffered AW is dropped by reset and must not pair with a later W
    s_awaddr = 32'h20; s_awvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model[2] = '0;
    s_wdata = 32'h24682468; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
    @(negedge clk);
    s_wvalid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("dropped_aw_no_commit", s_bvalid, 0);
    s_awaddr = 32'h24; s_awvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0;
    @(negedge clk);
    checkOutput("dropped_aw_bvalid", s_bvalid, 1);
    @(negedge clk);
    s_bready = 1'b0;
    model[9] = 32'h24682468;
    checkRegs("dropped_aw_regs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
